// File: rtl/imem_fetch_if.sv
// Fetch-side bus bundle: instruction memory port, redirect input and decode handshake.
// master = fetch controller, slave = memory/execute/decode side.
interface imem_fetch_if #(
    parameter int FQ_DEPTH = 2
);
    localparam int CW = $clog2(FQ_DEPTH + 1);

    logic [31:0]   imem_addr;
    logic [31:0]   imem_data;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          instr_valid;
    logic [31:0]   instr;
    logic [31:0]   instr_pc;
    logic          instr_ready;
    logic [CW-1:0] fq_count;
    logic          halted;

    modport master (
        output imem_addr, instr_valid, instr, instr_pc, fq_count, halted,
        input  imem_data, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_addr, instr_valid, instr, instr_pc, fq_count, halted,
        output imem_data, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// PC sequencer and fetch queue in front of a combinational instruction memory.
// Redirects flush the queue; pc outside memory parks the sequencer in HALT.
module imem_fetch_ctrl #(
    parameter int          IMEM_DEPTH = 32,
    parameter int          FQ_DEPTH   = 2,
    parameter logic [31:0] RESET_PC   = 32'd0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    imem_fetch_if.master bus
);
    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam logic [31:0] LIMIT = 32'(IMEM_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   q_instr [FQ_DEPTH];
    logic [31:0]   q_pc    [FQ_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_nxt;
    logic [CW-1:0] count;
    logic [31:0]   hd_instr;
    logic [31:0]   hd_pc;
    logic          pc_ok;
    logic          full;
    logic          valid;
    logic          push;
    logic          pop;

    assign pc_ok  = pc < LIMIT;
    assign full   = count == CW'(FQ_DEPTH);
    assign valid  = count != '0;
    assign rd_nxt = rd_ptr + PW'(1);
    assign pop    = valid && bus.instr_ready && !bus.redirect_valid;
    assign push   = (state == RUN) && pc_ok && (!full || pop)
                    && !bus.redirect_valid;

    assign bus.imem_addr   = pc;
    assign bus.instr_valid = valid;
    assign bus.instr       = hd_instr;
    assign bus.instr_pc    = hd_pc;
    assign bus.fq_count    = count;
    assign bus.halted      = (state == HALT);

    // Sequencer: run/idle/halt state and program counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else if (bus.redirect_valid) begin
            pc <= bus.redirect_pc;
            if (state != HALT || bus.redirect_pc < LIMIT)
                state <= en ? RUN : IDLE;
        end else begin
            if (push)
                pc <= pc + 32'd1;
            if (state != HALT)
                state <= !pc_ok ? HALT : (en ? RUN : IDLE);
        end
    end

    // Queue storage; contents beyond the valid window are don't-care.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= bus.imem_data;
            q_pc[wr_ptr]    <= pc;
        end
    end

    // Queue pointers, occupancy and registered head outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            hd_instr <= '0;
            hd_pc    <= '0;
        end else if (bus.redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_nxt;
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            if (push && (count == '0 || (pop && count == CW'(1)))) begin
                hd_instr <= bus.imem_data;
                hd_pc    <= pc;
            end else if (pop && count > CW'(1)) begin
                hd_instr <= q_instr[rd_nxt];
                hd_pc    <= q_pc[rd_nxt];
            end
        end
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a small combinational ROM model.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_imem_fetch_ctrl;
    logic clk;
    logic rst_n;
    logic en;
    int   total;
    int   bad;
    logic [31:0] rom [32];

    imem_fetch_if #(.FQ_DEPTH(2)) bus ();

    imem_fetch_ctrl #(
        .IMEM_DEPTH(32),
        .FQ_DEPTH(2),
        .RESET_PC(32'd0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.imem_data = 32'd0;
        if (bus.imem_addr < 32'd32)
            bus.imem_data = rom[bus.imem_addr[4:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++)
            rom[i] = 32'ha5000000 | 32'(i);
        rom[0]  = 32'h10010064;
        rom[1]  = 32'h4c1e0001;
        rom[21] = 32'h0ca000c9;

        rst_n = 1'b0;
        en    = 1'b0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        #3;
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_count", 32'(bus.fq_count), 32'd0);
        chk("rst_halt", 32'(bus.halted), 32'd0);
        chk("rst_addr", bus.imem_addr, 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_ipc", bus.instr_pc, 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Streaming fetch from reset.
        en = 1'b1;
        bus.instr_ready = 1'b1;
        step();
        chk("t1_valid0", 32'(bus.instr_valid), 32'd0);
        chk("t1_addr0", bus.imem_addr, 32'd0);
        step();
        chk("t1_valid1", 32'(bus.instr_valid), 32'd1);
        chk("t1_pc0", bus.instr_pc, 32'd0);
        chk("t1_ins0", bus.instr, 32'h10010064);
        chk("t1_addr1", bus.imem_addr, 32'd1);
        step();
        chk("t1_pc1", bus.instr_pc, 32'd1);
        chk("t1_ins1", bus.instr, 32'h4c1e0001);
        step();
        chk("t1_pc2", bus.instr_pc, 32'd2);
        chk("t1_cnt", 32'(bus.fq_count), 32'd1);

        // Backpressure from pc 0.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd0;
        bus.instr_ready    = 1'b0;
        step();
        chk("t2_rd_valid", 32'(bus.instr_valid), 32'd0);
        chk("t2_rd_addr", bus.imem_addr, 32'd0);
        bus.redirect_valid = 1'b0;
        step();
        chk("t2_cnt1", 32'(bus.fq_count), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_cnt2", 32'(bus.fq_count), 32'd2);
            chk("t2_addr", bus.imem_addr, 32'd2);
            chk("t2_head", bus.instr_pc, 32'd0);
        end

        // Full queue with ready: push and pop together.
        bus.instr_ready = 1'b1;
        step();
        chk("t3_pc1", bus.instr_pc, 32'd1);
        chk("t3_cnt", 32'(bus.fq_count), 32'd2);
        chk("t3_addr", bus.imem_addr, 32'd3);
        step();
        chk("t3_pc2", bus.instr_pc, 32'd2);
        chk("t3_cnt2", 32'(bus.fq_count), 32'd2);
        chk("t3_addr2", bus.imem_addr, 32'd4);

        // Redirect with two entries queued.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd21;
        step();
        chk("t4_valid", 32'(bus.instr_valid), 32'd0);
        chk("t4_cnt", 32'(bus.fq_count), 32'd0);
        chk("t4_addr", bus.imem_addr, 32'd21);
        bus.redirect_valid = 1'b0;
        step();
        chk("t4_vld21", 32'(bus.instr_valid), 32'd1);
        chk("t4_pc21", bus.instr_pc, 32'd21);
        chk("t4_ins21", bus.instr, 32'h0ca000c9);

        // Run off the end of memory.
        for (int k = 22; k < 32; k++) begin
            step();
            chk("t5_seq", bus.instr_pc, 32'(k));
            chk("t5_ins", bus.instr, rom[k]);
        end
        step();
        chk("t5_halt", 32'(bus.halted), 32'd1);
        chk("t5_valid", 32'(bus.instr_valid), 32'd0);
        chk("t5_addr", bus.imem_addr, 32'd32);
        step();
        chk("t5_nopush", 32'(bus.fq_count), 32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd0;
        step();
        chk("t5_unhalt", 32'(bus.halted), 32'd0);
        chk("t5_raddr", bus.imem_addr, 32'd0);
        bus.redirect_valid = 1'b0;
        step();
        chk("t5_resume", bus.instr_pc, 32'd0);
        chk("t5_rvalid", 32'(bus.instr_valid), 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd40;
        step();
        chk("t5_a40", bus.imem_addr, 32'd40);
        bus.redirect_valid = 1'b0;
        step();
        chk("t5_h40", 32'(bus.halted), 32'd1);
        chk("t5_c40", 32'(bus.fq_count), 32'd0);

        // Reset in the middle of a full queue.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd5;
        bus.instr_ready    = 1'b0;
        step();
        bus.redirect_valid = 1'b0;
        step();
        step();
        chk("t6_full", 32'(bus.fq_count), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(bus.instr_valid), 32'd0);
        chk("t6_cnt", 32'(bus.fq_count), 32'd0);
        chk("t6_addr", bus.imem_addr, 32'd0);
        step();
        rst_n = 1'b1;
        bus.instr_ready = 1'b1;
        step();
        step();
        chk("t6_pc0", bus.instr_pc, 32'd0);
        chk("t6_ins0", bus.instr, 32'h10010064);
        step();
        chk("t6_pc1", bus.instr_pc, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
